// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search engine:
// FSM state encoding and the width helper for the trial counter.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        DONE = 2'd2
    } sar_state_e;

    // Counter must hold the values 0..w inclusive.
    function automatic int ntry_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sar_search_if.sv
// Comparator bus between the search engine (master) and a magnitude comparator (slave).
interface sar_search_if #(
    parameter int W = 2
);
    // guess is registered by the master; the slave answers combinationally with
    // exactly one of gt/eq/ls set, settled before the next rising edge.
    logic [W-1:0] guess;
    logic         gt;
    logic         eq;
    logic         ls;

    modport master (output guess, input gt, eq, ls);
    modport slave  (input guess, output gt, eq, ls);
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search: walks guess from MSB to LSB using the
// comparator verdicts and reports the recovered target, early hit and protocol errors.
module sar_search
    import sar_pkg::*;
#(
    parameter  int W  = 2,
    localparam int NW = ntry_w(W),
    localparam int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    sar_search_if.master    cmp,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [W-1:0]    result,
    output logic            hit,
    output logic            err,
    output logic [NW-1:0]   ntry,
    output sar_state_e      state_dbg
);

    localparam logic [W-1:0] FIRST_GUESS = W'(1) << (W - 1);

    sar_state_e    state, state_n;
    logic [W-1:0]  guess, guess_n;
    logic [IW-1:0] idx, idx_n;
    logic [W-1:0]  result_n;
    logic          hit_n, err_n;
    logic [NW-1:0] ntry_n;
    logic [W-1:0]  trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            guess  <= '0;
            idx    <= '0;
            result <= '0;
            hit    <= 1'b0;
            err    <= 1'b0;
            ntry   <= '0;
        end else begin
            state  <= state_n;
            guess  <= guess_n;
            idx    <= idx_n;
            result <= result_n;
            hit    <= hit_n;
            err    <= err_n;
            ntry   <= ntry_n;
        end
    end

    always_comb begin
        state_n  = state;
        guess_n  = guess;
        idx_n    = idx;
        result_n = result;
        hit_n    = hit;
        err_n    = err;
        ntry_n   = ntry;
        trial    = guess;
        case (state)
            IDLE: begin
                if (start) begin
                    guess_n = FIRST_GUESS;
                    idx_n   = IW'(W - 1);
                    hit_n   = 1'b0;
                    err_n   = 1'b0;
                    ntry_n  = '0;
                    state_n = TRY;
                end
            end
            TRY: begin
                ntry_n = ntry + NW'(1);
                // A malformed verdict outranks eq and ends the search immediately.
                if (!$onehot({cmp.gt, cmp.eq, cmp.ls})) begin
                    err_n    = 1'b1;
                    result_n = guess;
                    state_n  = DONE;
                end else if (cmp.eq) begin
                    hit_n    = 1'b1;
                    result_n = guess;
                    state_n  = DONE;
                end else begin
                    if (cmp.gt) trial[idx] = 1'b0;
                    if (idx == '0) begin
                        result_n = trial;
                        hit_n    = 1'b0;
                        state_n  = DONE;
                    end else begin
                        trial[idx - IW'(1)] = 1'b1;
                        guess_n = trial;
                        idx_n   = idx - IW'(1);
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign cmp.guess = guess;
    assign busy      = (state == TRY);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: a 2-bit instance against a behavioural comparator
// over all targets plus fault/reset/back-to-back cases, and a 4-bit instance for target 9.
module tb_sar_search;
    import sar_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start2, start4;
    logic [1:0] target2;
    logic [3:0] target4;
    logic       inject;

    int vectors     = 0;
    int miscompares = 0;

    sar_search_if #(.W(2)) bus2 ();
    sar_search_if #(.W(4)) bus4 ();

    logic       busy2, done2, hit2, err2;
    logic [1:0] result2, ntry2;
    sar_state_e state2;
    logic       busy4, done4, hit4, err4;
    logic [3:0] result4;
    logic [2:0] ntry4;
    sar_state_e state4;

    // Clock / reset
    always #5 clk = ~clk;

    // 2-bit comparator: a,b = guess MSB,LSB; x,y = target MSB,LSB. inject forces gt=eq=1.
    logic a, b, x, y;
    assign a = bus2.guess[1];
    assign b = bus2.guess[0];
    assign x = target2[1];
    assign y = target2[0];
    assign bus2.gt = inject | ({a, b} >  {x, y});
    assign bus2.eq = inject | ({a, b} == {x, y});
    assign bus2.ls = ~inject & ({a, b} < {x, y});

    assign bus4.gt = (bus4.guess >  target4);
    assign bus4.eq = (bus4.guess == target4);
    assign bus4.ls = (bus4.guess <  target4);

    sar_search #(.W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cmp(bus2), .start(start2),
        .busy(busy2), .done(done2), .result(result2), .hit(hit2),
        .err(err2), .ntry(ntry2), .state_dbg(state2)
    );

    sar_search #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cmp(bus4), .start(start4),
        .busy(busy4), .done(done4), .result(result4), .hit(hit4),
        .err(err4), .ntry(ntry4), .state_dbg(state4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset2(input string tag);
        check({tag, ".guess"},  32'(bus2.guess), 0);
        check({tag, ".busy"},   32'(busy2),      0);
        check({tag, ".done"},   32'(done2),      0);
        check({tag, ".result"}, 32'(result2),    0);
        check({tag, ".hit"},    32'(hit2),       0);
        check({tag, ".err"},    32'(err2),       0);
        check({tag, ".ntry"},   32'(ntry2),      0);
        check({tag, ".state"},  32'(state2),     32'(IDLE));
    endtask

    // Driver: called at a negedge in IDLE; returns edges counted from the start edge (=1) to done.
    task automatic run2(input logic [1:0] t, output int edges);
        target2 = t;
        start2  = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        edges  = 1;
        while (!done2 && edges < 10) begin
            @(negedge clk);
            edges++;
        end
        if (!done2) check("run2.timeout", 32'(edges), 0);
    endtask

    // Expected outcome per 2-bit target: {result, hit, ntry, edges}
    typedef struct packed {
        logic [1:0] result;
        logic       hit;
        logic [1:0] ntry;
        logic [3:0] edges;
    } exp2_t;

    exp2_t exp2_tbl [4];
    logic [3:0] exp_q [$];
    logic [2:0] flag_q [$];

    initial begin
        int edges;
        int last;
        int pulses;
        logic [3:0] eg;
        logic [2:0] ef;

        exp2_tbl[0] = '{2'b00, 1'b0, 2'd2, 4'd3};
        exp2_tbl[1] = '{2'b01, 1'b1, 2'd2, 4'd3};
        exp2_tbl[2] = '{2'b10, 1'b1, 2'd1, 4'd2};
        exp2_tbl[3] = '{2'b11, 1'b1, 2'd2, 4'd3};

        rst_n = 1'b0; start2 = 1'b0; start4 = 1'b0; inject = 1'b0;
        target2 = '0; target4 = '0;
        repeat (2) @(negedge clk);
        check_reset2("reset");
        check("reset.guess4", 32'(bus4.guess), 0);
        check("reset.ntry4",  32'(ntry4),      0);
        rst_n = 1'b1;
        @(negedge clk);

        // All four targets through the comparator
        for (int t = 0; t < 4; t++) begin
            run2(2'(t), edges);
            check($sformatf("t%0d.result", t), 32'(result2), 32'(exp2_tbl[t].result));
            check($sformatf("t%0d.hit", t),    32'(hit2),    32'(exp2_tbl[t].hit));
            check($sformatf("t%0d.err", t),    32'(err2),    0);
            check($sformatf("t%0d.ntry", t),   32'(ntry2),   32'(exp2_tbl[t].ntry));
            check($sformatf("t%0d.edges", t),  32'(edges),   32'(exp2_tbl[t].edges));
            check($sformatf("t%0d.busy", t),   32'(busy2),   0);
            @(negedge clk);
            check($sformatf("t%0d.pulse", t),  32'(done2),   0);
            check($sformatf("t%0d.hold", t),   32'(result2), 32'(exp2_tbl[t].result));
        end

        // Malformed verdict on the first trial
        inject = 1'b1;
        run2(2'd1, edges);
        inject = 1'b0;
        check("inj.err",    32'(err2),    1);
        check("inj.hit",    32'(hit2),    0);
        check("inj.result", 32'(result2), 32'h2);
        check("inj.ntry",   32'(ntry2),   1);
        check("inj.edges",  32'(edges),   2);
        @(negedge clk);

        // Asynchronous reset in the middle of a search
        target2 = 2'd3;
        start2  = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("mid.busy_before", 32'(busy2), 1);
        #2 rst_n = 1'b0;
        #1 check_reset2("mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run2(2'd1, edges);
        check("post.result", 32'(result2), 32'h1);
        check("post.hit",    32'(hit2),    1);
        check("post.ntry",   32'(ntry2),   2);
        check("post.err",    32'(err2),    0);
        @(negedge clk);

        // start held high: done every 3 cycles for an eq-on-first-trial target
        target2 = 2'd2;
        start2  = 1'b1;
        last    = -1;
        pulses  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done2) begin
                pulses++;
                check("b2b.result", 32'(result2), 32'h2);
                if (last >= 0) check("b2b.spacing", 32'(c - last), 3);
                last = c;
            end
        end
        start2 = 1'b0;
        check("b2b.pulses", 32'(pulses), 7);
        repeat (2) @(negedge clk);

        // 4-bit instance, target 9
        exp_q  = '{4'b1000, 4'b1100, 4'b1010, 4'b1001};
        flag_q = '{3'b001, 3'b100, 3'b100, 3'b010};
        target4 = 4'd9;
        start4  = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        edges  = 1;
        while (!done4 && edges < 12) begin
            if (exp_q.size() > 0) begin
                eg = exp_q.pop_front();
                ef = flag_q.pop_front();
                check("w4.guess", 32'(bus4.guess), 32'(eg));
                check("w4.flags", 32'({bus4.gt, bus4.eq, bus4.ls}), 32'(ef));
            end else begin
                check("w4.extra_trial", 32'(bus4.guess), 32'(result4));
            end
            @(negedge clk);
            edges++;
        end
        check("w4.done",      32'(done4),        1);
        check("w4.edges",     32'(edges),        5);
        check("w4.result",    32'(result4),      32'h9);
        check("w4.hit",       32'(hit4),         1);
        check("w4.err",       32'(err4),         0);
        check("w4.ntry",      32'(ntry4),        4);
        check("w4.remaining", 32'(exp_q.size()), 0);
        @(negedge clk);
        check("w4.pulse", 32'(done4), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search engine that drives trial values into an external magnitude comparator and consumes its gt/eq/ls verdicts to recover an unknown W-bit target. This is the initiator side of the comparator interface: the comparator answers "is A greater than, equal to, or less than B"; this block asks the questions. The comparator's A port is driven by `guess`, its B port by the unknown target. The block produces the recovered value, a done pulse, and protocol-error detection.

## Interface
- `W`, default 2: data width. The MSB of `guess` maps to comparator input `a` and the LSB to `b` when W=2. Legal range is 1..8.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request a new search; honoured only in IDLE
- `gt`  in  1  comparator: guess > target
- `eq`  in  1  comparator: guess == target
- `ls`  in  1  comparator: guess < target
- `guess`  out  W  registered trial value to comparator A side
- `busy`  out  1  high from the cycle after start acceptance until done
- `done`  out  1  one-cycle pulse; result, hit, err and ntry are valid while high and held afterwards
- `result`  out  W  recovered target
- `hit`  out  1  search ended early on eq
- `err`  out  1  flags were not one-hot during a sampled trial
- `ntry`  out  $clog2(W+1)  number of trials sampled in the last search

## Operation
- States: IDLE, TRY, DONE.
- IDLE, start=1: set guess = 1<<(W-1), bit index idx = W-1, clear hit, err and ntry, then go to TRY.
- TRY: on each clock edge, sample {gt,eq,ls} and increment ntry.
  - Flags not exactly one-hot: err=1, result=guess, go to DONE.
  - eq: hit=1, result=guess, go to DONE.
  - gt: clear guess[idx].
  - ls: keep guess[idx].
  - If not finished and idx>0: set guess[idx-1]=1, decrement idx, stay in TRY.
  - If idx==0 without eq: result = guess after the clear/keep step, hit=0, go to DONE.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- `guess` holds its last value in DONE and IDLE until the next accepted start.
- `start` is ignored in TRY and DONE. No queuing.
- Comparator is combinational. Flags must settle within one cycle of `guess` changing.

## Timing
- Reset values: guess=0, busy=0, done=0, result=0, hit=0, err=0, ntry=0, state=IDLE.
- Start sampled at edge 0 → busy=1 and first guess on the bus after edge 0. Flags are sampled at edge 1, 2, …
- Worst-case latency: done asserted W+1 cycles after the start edge (W trials).
- Best-case latency: 2 cycles (eq on the first trial).
- Boundaries:
  - Target 0: every trial returns gt, result=0, hit=0.
  - Target all-ones: every trial except the last returns ls, the last returns eq.
  - Reset asserted mid-search: immediate return to IDLE with all outputs at reset values, regardless of clock.
  - start high continuously: a new search begins on the first IDLE cycle after DONE, so back-to-back searches are spaced W+2 cycles apart worst case.
  - err has priority over eq. err terminates the search without further trials.

## Structure
- Shared package `sar_pkg`: state enum (IDLE, TRY, DONE) and a function for the ntry width.
- Single flat module, no sub-modules.
- The bench instantiates the existing 2-bit comparator block as the responder. Mapping: guess → a,b; target → x,y; gt/eq/ls back to this block.

## Test plan
- W=2, each target 0..3 via the real comparator. Required results:
  - target=0: result=00, hit=0, ntry=2.
  - target=1: result=01, hit=1, ntry=2.
  - target=2: result=10, hit=1, ntry=1.
  - target=3: result=11, hit=1, ntry=2.
- Fault injection: force gt=eq=1 on the first trial → done at the 2nd edge with err=1, result=10, ntry=1.
- Reset mid-search: drop rst_n while in TRY → all outputs 0 with no clock edge. The next start behaves normally.
- start held high for 20 cycles with target=2: a done pulse every 3 cycles (W=2, eq on the first trial), result=10 each time. start pulses in TRY and DONE are ignored.
- W=4 build, target 9 (comparator model in the bench):
  - guess sequence 1000, 1100, 1010, 1001 with flags ls, gt, gt, eq.
  - result=1001, hit=1, ntry=4, done 5 cycles after start.
